// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: a registered PC, combinational next-PC selection,
// stall hold and a circular return-address stack for call/ret prediction.
module pc_sequencer #(
  parameter int unsigned     AW        = 32,
  parameter bit              BYTE_ADDR = 1'b0,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_i,
  input  logic [2:0]                   npcop_i,
  input  logic [15:0]                  imm16_i,
  input  logic [25:0]                  imm26_i,
  input  logic [AW-1:0]                rs_data_i,
  output logic [AW-1:0]                pc_o,
  output logic [AW-1:0]                npc_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_miss_o
);

  localparam int unsigned   PW  = $clog2(RAS_DEPTH);
  localparam int unsigned   CW  = PW + 1;
  localparam logic [AW-1:0] INC = BYTE_ADDR ? AW'(32'd4) : AW'(32'd1);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_BRANCH = 3'b001,
    OP_JUMP   = 3'b010,
    OP_CALL   = 3'b011,
    OP_JR     = 3'b100,
    OP_RET    = 3'b101
  } npc_op_e;

  function automatic logic [AW-1:0] branch_offset(input logic [15:0] imm);
    logic [AW-1:0] off;
    off = {{(AW-16){imm[15]}}, imm};
    if (BYTE_ADDR) begin
      off = off << 2;
    end else begin
      off = off;
    end
    return off;
  endfunction

  // Jumps keep the upper PC bits and replace the region selected by the index.
  function automatic logic [AW-1:0] jump_target(input logic [AW-1:0] pc, input logic [25:0] idx);
    logic [AW-1:0] t;
    if (BYTE_ADDR) begin
      t = {pc[AW-1:28], idx, 2'b00};
    end else begin
      t = {pc[AW-1:26], idx};
    end
    return t;
  endfunction

  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          miss_q, miss_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];

  logic [PW-1:0] ptr_m1_s;
  logic [AW-1:0] ras_top_s;
  logic [AW-1:0] seq_pc_s;
  logic [AW-1:0] npc_s;
  logic          push_s;
  logic          ras_valid_s;
  npc_op_e       op_s;

  assign op_s        = npc_op_e'(npcop_i);
  assign ptr_m1_s    = ptr_q - PW'(1'b1);
  assign ras_top_s   = ras_q[ptr_m1_s];
  assign seq_pc_s    = pc_q + INC;
  assign ras_valid_s = (cnt_q != {CW{1'b0}});

  // Next-PC selection; reserved encodings fall through to sequential.
  always_comb begin
    npc_s = seq_pc_s;
    case (op_s)
      OP_SEQ:    npc_s = seq_pc_s;
      OP_BRANCH: npc_s = seq_pc_s + branch_offset(imm16_i);
      OP_JUMP:   npc_s = jump_target(pc_q, imm26_i);
      OP_CALL:   npc_s = jump_target(pc_q, imm26_i);
      OP_JR:     npc_s = rs_data_i;
      OP_RET:    npc_s = ras_valid_s ? ras_top_s : rs_data_i;
      default:   npc_s = seq_pc_s;
    endcase
  end

  // State update for accepted cycles; stall holds everything and clears the miss pulse.
  always_comb begin
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    miss_d = 1'b0;
    push_s = 1'b0;
    if (!stall_i) begin
      pc_d = npc_s;
      case (op_s)
        OP_CALL: begin
          push_s = 1'b1;
          ptr_d  = ptr_q + PW'(1'b1);
          cnt_d  = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1'b1);
        end
        OP_RET: begin
          if (ras_valid_s) begin
            ptr_d = ptr_m1_s;
            cnt_d = cnt_q - CW'(1'b1);
          end else begin
            miss_d = 1'b1;
          end
        end
        default: begin
          push_s = 1'b0;
        end
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  // PC, stack pointer, occupancy, miss flag and stack entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      ptr_q  <= {PW{1'b0}};
      cnt_q  <= {CW{1'b0}};
      miss_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= {AW{1'b0}};
      end
    end else begin
      pc_q   <= pc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
      if (push_s) begin
        ras_q[ptr_q] <= seq_pc_s;
      end
    end
  end

  assign pc_o        = pc_q;
  assign npc_o       = npc_s;
  assign ras_count_o = cnt_q;
  assign ras_miss_o  = miss_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: a word-addressed and a byte-addressed instance share stimulus;
// each step checks the instance the expected values were worked out for.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [2:0]  npcop;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;

  logic [31:0] w_pc, w_npc, b_pc, b_npc;
  logic [2:0]  w_cnt, b_cnt;
  logic        w_miss, b_miss;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.AW(32), .BYTE_ADDR(1'b0), .RESET_PC(32'h0), .RAS_DEPTH(4)) u_word (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .npcop_i(npcop), .imm16_i(imm16),
    .imm26_i(imm26), .rs_data_i(rs_data), .pc_o(w_pc), .npc_o(w_npc),
    .ras_count_o(w_cnt), .ras_miss_o(w_miss)
  );

  pc_sequencer #(.AW(32), .BYTE_ADDR(1'b1), .RESET_PC(32'h0), .RAS_DEPTH(4)) u_byte (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .npcop_i(npcop), .imm16_i(imm16),
    .imm26_i(imm26), .rs_data_i(rs_data), .pc_o(b_pc), .npc_o(b_npc),
    .ras_count_o(b_cnt), .ras_miss_o(b_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    stall   = 1'b0;
    npcop   = 3'b000;
    imm16   = 16'h0;
    imm26   = 26'h0;
    rs_data = 32'h0;
    step();
    step();
    chk("reset_pc", w_pc, 64'h0);
    chk("reset_cnt", w_cnt, 64'h0);
    chk("reset_miss", w_miss, 64'h0);

    // 1: sequential counting after reset release
    rst = 1'b0;
    #1;
    chk("seq_npc0", w_npc, 64'h1);
    step(); chk("seq_pc1", w_pc, 64'h1);
    step(); chk("seq_pc2", w_pc, 64'h2);
    step(); chk("seq_pc3", w_pc, 64'h3);
    chk("seq_cnt", w_cnt, 64'h0);

    // 2: branches in both modes
    npcop = 3'b100; rs_data = 32'h10;
    step(); chk("jr_pc", w_pc, 64'h10);
    npcop = 3'b001; imm16 = 16'hFFFE;
    #1;
    chk("br_word_neg", w_npc, 64'h0F);
    chk("br_byte_neg", b_npc, 64'h0C);
    npcop = 3'b100; rs_data = 32'h100;
    step();
    npcop = 3'b001; imm16 = 16'h0004;
    #1;
    chk("br_byte_pos", b_npc, 64'h114);
    chk("br_word_pos", w_npc, 64'h105);

    // 3: jump and silent wrap
    npcop = 3'b100; rs_data = 32'hA000_0000;
    step();
    npcop = 3'b010; imm26 = 26'h10;
    #1;
    chk("jmp_byte", b_npc, 64'hA000_0040);
    chk("jmp_word", w_npc, 64'hA000_0010);
    npcop = 3'b100; rs_data = 32'hFFFF_FFFC;
    step();
    npcop = 3'b000;
    #1;
    chk("wrap_byte_npc", b_npc, 64'h0);
    chk("wrap_word_npc", w_npc, 64'hFFFF_FFFD);
    step(); chk("wrap_byte_pc", b_pc, 64'h0);

    // 4: call/ret in byte mode, then a ret on the empty stack
    npcop = 3'b100; rs_data = 32'h40;
    step();
    npcop = 3'b011; imm26 = 26'h800;
    #1;
    chk("call_byte_npc", b_npc, 64'h2000);
    step();
    chk("call_byte_pc", b_pc, 64'h2000);
    chk("call_byte_cnt", b_cnt, 64'h1);
    npcop = 3'b101; rs_data = 32'h300;
    #1;
    chk("ret_byte_npc", b_npc, 64'h44);
    chk("ret_word_npc", w_npc, 64'h41);
    step();
    chk("ret_byte_pc", b_pc, 64'h44);
    chk("ret_byte_cnt", b_cnt, 64'h0);
    chk("ret_byte_miss", b_miss, 64'h0);
    #1;
    chk("ret_empty_npc", b_npc, 64'h300);
    step();
    chk("ret_empty_pc", b_pc, 64'h300);
    chk("ret_empty_miss", b_miss, 64'h1);
    chk("ret_empty_cnt", b_cnt, 64'h0);
    npcop = 3'b000;
    step();
    chk("miss_clears", b_miss, 64'h0);

    // 5: overflow a 4-deep stack in word mode
    rst = 1'b1;
    step();
    rst = 1'b0;
    npcop = 3'b100; rs_data = 32'h1;
    step();
    chk("ovf_start_pc", w_pc, 64'h1);
    for (int i = 1; i <= 5; i++) begin
      npcop = 3'b011; imm26 = 26'(i + 1);
      step();
    end
    chk("ovf_pc", w_pc, 64'h6);
    chk("ovf_cnt", w_cnt, 64'h4);
    npcop = 3'b101; rs_data = 32'h777;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ovf_ret%0d_npc", i), w_npc, 64'(6 - i));
      step();
      chk($sformatf("ovf_ret%0d_cnt", i), w_cnt, 64'(3 - i));
      chk($sformatf("ovf_ret%0d_miss", i), w_miss, 64'h0);
    end
    #1;
    chk("ovf_ret4_npc", w_npc, 64'h777);
    step();
    chk("ovf_ret4_miss", w_miss, 64'h1);
    chk("ovf_ret4_cnt", w_cnt, 64'h0);

    // 6: stall holds PC and stack, then reset lands mid-stall
    npcop = 3'b011; imm26 = 26'h10;
    step();
    chk("pre_stall_pc", w_pc, 64'h10);
    chk("pre_stall_cnt", w_cnt, 64'h1);
    chk("pre_stall_miss", w_miss, 64'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_pc", i), w_pc, 64'h10);
      chk($sformatf("stall%0d_cnt", i), w_cnt, 64'h1);
    end
    chk("stall_npc", w_npc, 64'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", w_pc, 64'h0);
    chk("async_rst_cnt", w_cnt, 64'h0);
    chk("async_rst_byte_pc", b_pc, 64'h0);
    stall = 1'b0;
    step();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
